// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_pkg : definitions shared by the sequence generator, the sequence      |
// |           detector and their benches (state codes, widths)                |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
package seq_pkg;

   localparam int SEQ_WIDTH = 24;
   localparam int LEN_W     = 5;

   typedef logic [LEN_W-1:0] len_t;

   localparam len_t LEN_ONE = len_t'(1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_len_clamp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_len_clamp : maps a requested pattern length to the effective length;  |
// |                 0 or anything above WIDTH becomes WIDTH                   |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module seq_len_clamp
   import seq_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH
) (
   input  logic [LEN_W-1:0] load_len,
   output logic [LEN_W-1:0] eff_len
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);

   always_comb begin
      eff_len = load_len;
      if ((load_len == '0) || (load_len > MAX_LEN)) begin
         eff_len = MAX_LEN;
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_gen_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_gen_fsm : serialises a loaded pattern MSB-first, one-shot or cyclic   |
// |               until stop. Optional macro SEQ_GEN_PAUSE_EN adds `pause`.   |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module seq_gen_fsm
   import seq_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH
) (
   input  logic             Clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LEN_W-1:0] load_len,
   // "repeat" is a reserved word, hence the suffix
   input  logic             repeat_en,
   input  logic             stop,
`ifdef SEQ_GEN_PAUSE_EN
   input  logic             pause,
`endif
   output logic             load_ready,
   output logic             x,
   output logic             x_valid,
   output logic             x_last,
   output logic             busy
);

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic             rpt_q, rpt_d;
   logic             stop_q, stop_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;

   logic [LEN_W-1:0] eff_len;
   logic             pause_act;
   logic             stop_seen;
   logic             ending;

`ifdef SEQ_GEN_PAUSE_EN
   assign pause_act = pause & (state_q == SHIFT);
`else
   assign pause_act = 1'b0;
`endif

   seq_len_clamp #(
      .WIDTH    (WIDTH)
   ) u_len_clamp (
      .load_len (load_len),
      .eff_len  (eff_len)
   );

   // A stop arriving on the final bit of a pass ends transmission on that bit.
   assign stop_seen = stop_q | stop;
   assign ending    = (idx_q == '0) & (~rpt_q | stop_seen);

   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      len_d     = len_q;
      idx_d     = idx_q;
      rpt_d     = rpt_q;
      stop_d    = stop_q;
      x_d       = x_q;
      x_valid_d = x_valid_q;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               pat_d     = load_data;
               len_d     = eff_len;
               idx_d     = eff_len - LEN_ONE;
               rpt_d     = repeat_en;
               stop_d    = 1'b0;
               x_d       = load_data[eff_len - LEN_ONE];
               x_valid_d = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            stop_d = stop_seen;
            if (!pause_act) begin
               if (ending) begin
                  state_d   = IDLE;
                  idx_d     = '0;
                  rpt_d     = 1'b0;
                  stop_d    = 1'b0;
                  x_d       = 1'b0;
                  x_valid_d = 1'b0;
               end else if (idx_q == '0) begin
                  idx_d = len_q - LEN_ONE;
                  x_d   = pat_q[len_q - LEN_ONE];
               end else begin
                  idx_d = idx_q - LEN_ONE;
                  x_d   = pat_q[idx_q - LEN_ONE];
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         rpt_q     <= 1'b0;
         stop_q    <= 1'b0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         rpt_q     <= rpt_d;
         stop_q    <= stop_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
      end
   end

   assign load_ready = (state_q == IDLE);
   assign busy       = (state_q == SHIFT);
   assign x          = x_q;
   assign x_valid    = x_valid_q & ~pause_act;
   assign x_last     = (state_q == SHIFT) & ending & ~pause_act;

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_gen_fsm : table vectors, reset abort, optional pause and random    |
// |                  loads against a bit-stream model of seq_gen_fsm          |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_seq_gen_fsm;

   localparam int W = 24;

   logic          Clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_valid = 1'b0;
   logic [W-1:0]  load_data = '0;
   logic [4:0]    load_len = '0;
   logic          repeat_en = 1'b0;
   logic          stop = 1'b0;
   logic          pause = 1'b0;
   logic          load_ready, x, x_valid, x_last, busy;

   int checks = 0;
   int errors = 0;
   bit exp_q[$];

   typedef struct {
      logic [23:0] data;
      logic [4:0]  len;
      logic        rpt;
      int          stop_at;
      logic        hold;
      int          n;
      logic [63:0] bits;
   } vec_t;

   vec_t vecs[8];

   always #5 Clk = ~Clk;

   seq_gen_fsm #(.WIDTH(W)) dut (
      .Clk        (Clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_len   (load_len),
      .repeat_en  (repeat_en),
      .stop       (stop),
`ifdef SEQ_GEN_PAUSE_EN
      .pause      (pause),
`endif
      .load_ready (load_ready),
      .x          (x),
      .x_valid    (x_valid),
      .x_last     (x_last),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Load one pattern and follow the stream against exp_q, then check the idle return.
   task automatic run_load(input string tag, input logic [23:0] data, input logic [4:0] len,
                           input logic rpt, input int stop_at, input logic hold, input int pause_at);
      int  nexp;
      int  cnt;
      int  pause_left;
      bit  paused;
      nexp       = exp_q.size();
      cnt        = 0;
      pause_left = 3;
      chk({tag, " ready before load"}, load_ready, 1);
      load_data  = data;
      load_len   = len;
      repeat_en  = rpt;
      load_valid = 1'b1;
      tick();
      if (hold) load_data = ~data;
      else      load_valid = 1'b0;
      while (cnt < nexp) begin
         paused = (pause_at != 0) && (cnt == pause_at - 1) && (pause_left > 0);
         pause  = paused;
         stop   = (stop_at != 0) && (cnt + 1 == stop_at) && !paused;
         #1;
         chk($sformatf("%s x_valid c%0d", tag, cnt), x_valid, !paused);
         chk($sformatf("%s busy c%0d", tag, cnt), busy, 1);
         if (paused) begin
            chk($sformatf("%s x_last paused", tag), x_last, 0);
            pause_left--;
         end else begin
            chk($sformatf("%s x bit%0d", tag, cnt + 1), x, exp_q[cnt]);
            chk($sformatf("%s x_last bit%0d", tag, cnt + 1), x_last, (cnt == nexp - 1));
            cnt++;
         end
         tick();
      end
      stop       = 1'b0;
      pause      = 1'b0;
      load_valid = 1'b0;
      #1;
      chk({tag, " idle busy"}, busy, 0);
      chk({tag, " idle x_valid"}, x_valid, 0);
      chk({tag, " idle x_last"}, x_last, 0);
      chk({tag, " idle x"}, x, 0);
      chk({tag, " idle ready"}, load_ready, 1);
      tick();
      chk({tag, " ready 2 cycles on"}, load_ready, 1);
   endtask

   // Expected stream straight from the rules: clamp the length, replay the
   // pattern MSB-first, and in repeat mode finish the pass in which stop lands.
   task automatic model(input logic [23:0] data, input logic [4:0] len, input logic rpt, input int stop_at);
      int eff;
      int total;
      eff   = (len == 0 || len > W) ? W : int'(len);
      total = rpt ? ((stop_at + eff - 1) / eff) * eff : eff;
      exp_q.delete();
      for (int i = 0; i < total; i++) exp_q.push_back(data[eff - 1 - (i % eff)]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{24'h0CD124, 5'd20, 1'b0, 0, 1'b0, 20, 64'hCD124};
      vecs[1] = '{24'h000012, 5'd5,  1'b1, 7, 1'b0, 10, 64'b1001010010};
      vecs[2] = '{24'hFFFFFE, 5'd0,  1'b0, 0, 1'b0, 24, 64'hFFFFFE};
      vecs[3] = '{24'h0CD124, 5'd20, 1'b0, 0, 1'b1, 20, 64'hCD124};
      vecs[4] = '{24'hA5A5A5, 5'd31, 1'b0, 0, 1'b0, 24, 64'hA5A5A5};
      vecs[5] = '{24'h000001, 5'd1,  1'b0, 0, 1'b0, 1,  64'b1};
      vecs[6] = '{24'h000001, 5'd1,  1'b1, 3, 1'b0, 3,  64'b111};
      vecs[7] = '{24'h000005, 5'd3,  1'b1, 3, 1'b0, 3,  64'b101};

      repeat (3) tick();
      chk("reset busy", busy, 0);
      chk("reset x_valid", x_valid, 0);
      chk("reset x_last", x_last, 0);
      chk("reset x", x, 0);
      chk("reset ready", load_ready, 1);
      rst = 1'b0;
      tick();

      foreach (vecs[v]) begin
         exp_q.delete();
         for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].bits[vecs[v].n - 1 - i]);
         run_load($sformatf("vec%0d", v), vecs[v].data, vecs[v].len, vecs[v].rpt,
                  vecs[v].stop_at, vecs[v].hold, 0);
      end

      // Reset on the 4th bit of a 20-bit send aborts with no x_last pulse.
      load_data  = 24'h0CD124;
      load_len   = 5'd20;
      repeat_en  = 1'b0;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("rst bit4 x_valid", x_valid, 1);
      chk("rst bit4 x", x, 0);
      chk("rst bit4 x_last", x_last, 0);
      tick();
      chk("rst abort x_valid", x_valid, 0);
      chk("rst abort busy", busy, 0);
      chk("rst abort ready", load_ready, 1);
      chk("rst abort x_last", x_last, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("post rst quiet x_last %0d", i), x_last, 0);
         chk($sformatf("post rst quiet x_valid %0d", i), x_valid, 0);
      end

`ifdef SEQ_GEN_PAUSE_EN
      model(24'h0CD124, 5'd20, 1'b0, 0);
      run_load("pause", 24'h0CD124, 5'd20, 1'b0, 0, 1'b0, 2);
`endif

      for (int r = 0; r < 30; r++) begin
         logic [23:0] d;
         logic [4:0]  l;
         logic        rp;
         int          eff;
         int          sa;
         d   = 24'($urandom);
         l   = 5'($urandom_range(0, 31));
         rp  = 1'($urandom_range(0, 1));
         eff = (l == 0 || l > W) ? W : int'(l);
         sa  = rp ? int'($urandom_range(1, 3 * eff)) : int'($urandom_range(0, eff));
         model(d, l, rp, sa);
         run_load($sformatf("rnd%0d", r), d, l, rp, sa, 1'($urandom_range(0, 1)), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
